// File: rtl/activation_write_buffer_if.sv
// activation_write_buffer_if: producer-side and cache-side buses of activation_write_buffer
// With ACT_WB_AUTOADDR_EN the producer bus carries no address; the buffer generates it.
interface act_wb_in_if #(parameter int ADDRESS_WIDTH = 21, parameter int WORD_SIZE = 16);
  logic in_valid;
  logic in_ready;
  logic [WORD_SIZE-1:0] in_activation;
`ifdef ACT_WB_AUTOADDR_EN
  modport master(output in_valid, in_activation, input in_ready);
  modport slave(input in_valid, in_activation, output in_ready);
`else
  logic [ADDRESS_WIDTH-1:0] in_address;
  modport master(output in_valid, in_activation, in_address, input in_ready);
  modport slave(input in_valid, in_activation, in_address, output in_ready);
`endif
endinterface

interface act_wb_cache_if #(parameter int ADDRESS_WIDTH = 21, parameter int WORD_SIZE = 16);
  logic cache_request;
  logic cache_read_write;
  logic [ADDRESS_WIDTH-1:0] cache_address;
  logic [WORD_SIZE-1:0] cache_activation_in;
  logic cache_valid;
  logic cache_error;
  modport master(output cache_request, cache_read_write, cache_address, cache_activation_in,
                 input cache_valid, cache_error);
  modport slave(input cache_request, cache_read_write, cache_address, cache_activation_in,
                output cache_valid, cache_error);
endinterface

// File: rtl/activation_write_buffer.sv
// activation_write_buffer: FIFO of activations issued as two-cycle writes to the activation cache
// ACT_WB_AUTOADDR_EN: addresses come from an internal counter loaded by start/base_address.
module activation_write_buffer #(
  parameter int DEPTH = 8,
  parameter int ADDRESS_WIDTH = 21,
  parameter int WORD_SIZE = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef ACT_WB_AUTOADDR_EN
  input  logic start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
`endif
  act_wb_in_if.slave in_if,
  act_wb_cache_if.master cache_if,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic busy,
  output logic halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PHASE_A, PHASE_B, HALT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem_d [DEPTH];
  logic [WORD_SIZE-1:0] act_mem_q [DEPTH];
  logic [WORD_SIZE-1:0] act_mem_d [DEPTH];
  logic [ADDRESS_WIDTH-1:0] push_addr;
  logic push, pop, active;
`ifdef ACT_WB_AUTOADDR_EN
  logic [ADDRESS_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  always_comb begin
    push_addr = start ? base_address : addr_cnt_q;
    addr_cnt_d = push ? push_addr + ADDRESS_WIDTH'(1) : push_addr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) addr_cnt_q <= '0;
    else addr_cnt_q <= addr_cnt_d;
`else
  always_comb push_addr = in_if.in_address;
`endif
  always_comb begin
    halted = state_q == HALT;
    in_if.in_ready = count_q < CW'(DEPTH) && !halted;
    push = in_if.in_valid && in_if.in_ready;
    // an erroring cache has not committed the write, so the head is kept
    pop = state_q == PHASE_B && !cache_if.cache_error;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    addr_mem_d = addr_mem_q;
    act_mem_d = act_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = push_addr;
      act_mem_d[wr_ptr_q] = in_if.in_activation;
    end
    case (state_q)
      IDLE:    state_d = count_q != '0 ? PHASE_A : IDLE;
      PHASE_A: state_d = cache_if.cache_valid ? PHASE_B : HALT;
      PHASE_B: state_d = count_d != '0 ? PHASE_A : IDLE;
      default: state_d = HALT;
    endcase
    if (cache_if.cache_error) state_d = HALT;
  end
  // read_write stays 1 whenever request is 0 so the cache never sees an idle write
  always_comb begin
    active = state_q == PHASE_A || state_q == PHASE_B;
    cache_if.cache_request = active;
    cache_if.cache_read_write = !active;
    cache_if.cache_address = active ? addr_mem_q[rd_ptr_q] : '0;
    cache_if.cache_activation_in = active ? act_mem_q[rd_ptr_q] : '0;
    count = count_q;
    busy = count_q != '0 || state_q != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      addr_mem_q <= '{default: '0};
      act_mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      addr_mem_q <= addr_mem_d;
      act_mem_q <= act_mem_d;
    end
endmodule

// File: tb/tb_activation_write_buffer.sv
// tb_activation_write_buffer: scoreboard bench; a small cache model supplies cache_valid per set.
`timescale 1ns/1ps
module tb_activation_write_buffer;
  localparam int DEPTH = 8;
  localparam int AW = 21;
  localparam int WS = 16;
  localparam int NWAYS = 5;
  typedef struct packed {logic [AW-1:0] addr; logic [WS-1:0] act;} wr_t;
  logic clk = 0;
  logic reset = 1;
  logic cache_error = 0;
  logic [3:0] count;
  logic busy, halted;
`ifdef ACT_WB_AUTOADDR_EN
  logic start = 0;
  logic [AW-1:0] base_address = '0;
  bit auto_mode = 0;
`endif
  wr_t expq[$];
  wr_t e;
  int checks = 0;
  int errors = 0;
  int used [256];
  int run = 0;
  bit saw_full;
  logic [AW-1:0] a_addr;
  logic [WS-1:0] a_act;

  act_wb_in_if #(.ADDRESS_WIDTH(AW), .WORD_SIZE(WS)) in_if();
  act_wb_cache_if #(.ADDRESS_WIDTH(AW), .WORD_SIZE(WS)) cache_if();

  activation_write_buffer #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .WORD_SIZE(WS)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ACT_WB_AUTOADDR_EN
    .start(start),
    .base_address(base_address),
`endif
    .in_if(in_if),
    .cache_if(cache_if),
    .count(count),
    .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign cache_if.cache_valid = used[cache_if.cache_address[7:0]] < NWAYS;
  assign cache_if.cache_error = cache_error;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // cache model: run counts consecutive request cycles; odd run at an edge = end of write phase
  always @(posedge clk or posedge reset)
    if (reset) begin
      run <= 0;
      foreach (used[i]) used[i] <= 0;
    end else if (cache_if.cache_request) begin
      run <= run + 1;
      if (run % 2 == 1) used[cache_if.cache_address[7:0]] <= used[cache_if.cache_address[7:0]] + 1;
    end else run <= 0;

  always @(negedge clk)
    if (!reset) begin
      if (!cache_if.cache_request) check("rw_idle", 32'(cache_if.cache_read_write), 1);
      else begin
        check("rw_write", 32'(cache_if.cache_read_write), 0);
        if (run % 2 == 0) begin
          a_addr = cache_if.cache_address;
          a_act = cache_if.cache_activation_in;
        end else begin
          check("hold_addr", 32'(cache_if.cache_address), 32'(a_addr));
          check("hold_act", 32'(cache_if.cache_activation_in), 32'(a_act));
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h expected no write", cache_if.cache_address);
          end else begin
            e = expq.pop_front();
            check("wr_addr", 32'(cache_if.cache_address), 32'(e.addr));
            check("wr_act", 32'(cache_if.cache_activation_in), 32'(e.act));
          end
        end
      end
    end

  task automatic push(input logic [AW-1:0] a, input logic [WS-1:0] d);
    int t = 0;
    in_if.in_valid = 1;
    in_if.in_activation = d;
`ifdef ACT_WB_AUTOADDR_EN
    start = !auto_mode;
    base_address = a;
`else
    in_if.in_address = a;
`endif
    while (!in_if.in_ready && t < 200) begin
      if (!halted) check("full_at_stall", 32'(count), DEPTH);
      saw_full = 1;
      @(negedge clk);
      t++;
    end
    if (!in_if.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
    end else expq.push_back({a, d});
    @(negedge clk);
    in_if.in_valid = 0;
`ifdef ACT_WB_AUTOADDR_EN
    start = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1;
    cache_error = 0;
    expq.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(busy), 0);
  endtask

  initial begin
    int t;
    in_if.in_valid = 0;
    in_if.in_activation = '0;
`ifndef ACT_WB_AUTOADDR_EN
    in_if.in_address = '0;
`endif
    @(negedge clk);
    check("rst_req", 32'(cache_if.cache_request), 0);
    check("rst_rw", 32'(cache_if.cache_read_write), 1);
    check("rst_addr", 32'(cache_if.cache_address), 0);
    check("rst_act", 32'(cache_if.cache_activation_in), 0);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    reset = 0;
    @(negedge clk);
    check("rst_ready", 32'(in_if.in_ready), 1);

    do_reset();
    push(21'h000105, 16'h1234);
    check("single_c1_req", 32'(cache_if.cache_request), 0);
    @(negedge clk);
    check("single_c2_req", 32'(cache_if.cache_request), 1);
    check("single_c2_addr", 32'(cache_if.cache_address), 32'h105);
    check("single_c2_act", 32'(cache_if.cache_activation_in), 32'h1234);
    @(negedge clk);
    check("single_c3_req", 32'(cache_if.cache_request), 1);
    @(negedge clk);
    check("single_c4_req", 32'(cache_if.cache_request), 0);
    check("single_count", 32'(count), 0);
    check("single_busy", 32'(busy), 0);

    do_reset();
    saw_full = 0;
    for (int i = 0; i < 16; i++) push(AW'(i), 16'hA000 + 16'(i));
    wait_idle("burst_drain");
    check("burst_saw_full", 32'(saw_full), 1);
    check("burst_left", expq.size(), 0);

    do_reset();
    for (int i = 0; i < 6; i++) push({13'(i + 1), 8'h05}, 16'h5000 + 16'(i));
    t = 0;
    while (!halted && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("setfull_halted", 32'(halted), 1);
    check("setfull_count", 32'(count), 1);
    check("setfull_req", 32'(cache_if.cache_request), 0);
    check("setfull_ready", 32'(in_if.in_ready), 0);
    check("setfull_left", expq.size(), 1);

    do_reset();
    push(21'h0ABC33, 16'hBEEF);
    t = 0;
    while (!(cache_if.cache_request && run % 2 == 1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("err_in_phase_b", 32'(cache_if.cache_request), 1);
    cache_error = 1;
    @(negedge clk);
    cache_error = 0;
    check("err_halted", 32'(halted), 1);
    check("err_ready", 32'(in_if.in_ready), 0);
    check("err_req", 32'(cache_if.cache_request), 0);
    check("err_rw", 32'(cache_if.cache_read_write), 1);
    @(negedge clk);
    check("err_sticky", 32'(halted), 1);

    do_reset();
    for (int i = 0; i < 4; i++) push(AW'(32'h201 + i), 16'h7000 + 16'(i));
    check("mid_phase_a", 32'(cache_if.cache_request && run % 2 == 0), 1);
    check("mid_count", 32'(count), 3);
    reset = 1;
    expq.delete();
    #1;
    check("mid_req", 32'(cache_if.cache_request), 0);
    check("mid_rw", 32'(cache_if.cache_read_write), 1);
    check("mid_addr", 32'(cache_if.cache_address), 0);
    check("mid_act", 32'(cache_if.cache_activation_in), 0);
    check("mid_count0", 32'(count), 0);
    check("mid_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("mid_ready", 32'(in_if.in_ready), 1);
    @(negedge clk);

`ifdef ACT_WB_AUTOADDR_EN
    do_reset();
    start = 1;
    base_address = 21'h1FFFFF;
    @(negedge clk);
    start = 0;
    auto_mode = 1;
    push(21'h1FFFFF, 16'h0001);
    push(21'h000000, 16'h0002);
    wait_idle("auto_drain");
    check("auto_left", expq.size(), 0);
    auto_mode = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
